// File: rtl/pipeline_stall_controller.sv
// Central pipeline sequencer: merges load-use stalls, branch flushes and data-memory
// busy into pipeline-register write-enable, bubble and flush controls, with saturating
// stall/flush performance counters.
module pipeline_stall_controller #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_hazard,
  input  logic             branch_taken_EX,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned CW = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;

  // Control word order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write
  localparam logic [5:0] CTL_NORMAL = 6'b110101;
  localparam logic [5:0] CTL_LSTALL = 6'b000111;
  localparam logic [5:0] CTL_FLUSH  = 6'b111111;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  state_t        ret, ret_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [5:0]    ctl;
  logic          flush_cycle;

  // Next-state and zero-latency control decode from current state and inputs
  always_comb begin
    state_nxt   = RUN;
    ret_nxt     = ret;
    cnt_nxt     = cnt;
    ctl         = CTL_NORMAL;
    flush_cycle = 1'b0;
    case (state)
      LOAD_STALL: begin
        if (mem_busy) begin
          ctl       = 6'b000000;
          ret_nxt   = LOAD_STALL;
          state_nxt = MEM_WAIT;
        end else begin
          ctl = CTL_LSTALL;
          if (cnt == CW'(1)) begin
            state_nxt = RUN;
          end else begin
            cnt_nxt   = CW'(cnt - CW'(1));
            state_nxt = LOAD_STALL;
          end
        end
      end
      MEM_WAIT: begin
        // The exit cycle still freezes the front end but lets EX/MEM capture the result
        ctl       = {5'b00000, ~mem_busy};
        state_nxt = mem_busy ? MEM_WAIT : ret;
      end
      default: begin
        // RUN, and the unreachable encoding 3, which behaves as RUN
        if (mem_busy) begin
          ctl       = 6'b000000;
          ret_nxt   = RUN;
          state_nxt = MEM_WAIT;
        end else if (branch_taken_EX) begin
          // The dependent instruction is squashed, so the flush wins over a load-use stall
          ctl         = CTL_FLUSH;
          flush_cycle = 1'b1;
          state_nxt   = RUN;
        end else if (load_use_hazard) begin
          ctl       = CTL_LSTALL;
          cnt_nxt   = CW'(LOAD_STALL_CYCLES - 1);
          state_nxt = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL : RUN;
        end else begin
          ctl       = CTL_NORMAL;
          state_nxt = RUN;
        end
      end
    endcase
    if (rst) begin
      ctl         = 6'b000000;
      flush_cycle = 1'b0;
    end
  end

  assign {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write} = ctl;
  assign ctrl_state = state;

  // Sequencer state, stall down-counter and return state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      ret   <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ret   <= ret_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= CNT_W'(stall_count + CNT_W'(1));
      end
      if (flush_cycle && (flush_count != {CNT_W{1'b1}})) begin
        flush_count <= CNT_W'(flush_count + CNT_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: three instances (1-cycle stall,
// 3-cycle stall, 4-bit counters) share stimulus; expected values go through a scoreboard.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_use_hazard = 1'b0;
  logic branch_taken_EX = 1'b0;
  logic mem_busy = 1'b0;

  always #5 clk = ~clk;

  logic [2:0][5:0]  ctl;
  logic [2:0][1:0]  st;
  logic [1:0][15:0] sc16;
  logic [1:0][15:0] fc16;
  logic [3:0]       sc4, fc4;

  pipeline_stall_controller #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_lsc1 (
    .clk(clk), .rst(rst), .load_use_hazard(load_use_hazard), .branch_taken_EX(branch_taken_EX),
    .mem_busy(mem_busy), .pc_write(ctl[0][5]), .if_id_write(ctl[0][4]), .if_id_flush(ctl[0][3]),
    .id_ex_write(ctl[0][2]), .id_ex_bubble(ctl[0][1]), .ex_mem_write(ctl[0][0]),
    .ctrl_state(st[0]), .stall_count(sc16[0]), .flush_count(fc16[0]));

  pipeline_stall_controller #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u_lsc3 (
    .clk(clk), .rst(rst), .load_use_hazard(load_use_hazard), .branch_taken_EX(branch_taken_EX),
    .mem_busy(mem_busy), .pc_write(ctl[1][5]), .if_id_write(ctl[1][4]), .if_id_flush(ctl[1][3]),
    .id_ex_write(ctl[1][2]), .id_ex_bubble(ctl[1][1]), .ex_mem_write(ctl[1][0]),
    .ctrl_state(st[1]), .stall_count(sc16[1]), .flush_count(fc16[1]));

  pipeline_stall_controller #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) u_cnt4 (
    .clk(clk), .rst(rst), .load_use_hazard(load_use_hazard), .branch_taken_EX(branch_taken_EX),
    .mem_busy(mem_busy), .pc_write(ctl[2][5]), .if_id_write(ctl[2][4]), .if_id_flush(ctl[2][3]),
    .id_ex_write(ctl[2][2]), .id_ex_bubble(ctl[2][1]), .ex_mem_write(ctl[2][0]),
    .ctrl_state(st[2]), .stall_count(sc4), .flush_count(fc4));

  // Control words: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write
  localparam logic [5:0] NRM = 6'b110101;
  localparam logic [5:0] LST = 6'b000111;
  localparam logic [5:0] FLS = 6'b111111;
  localparam logic [5:0] FRZ = 6'b000000;
  localparam logic [5:0] FRX = 6'b000001;
  localparam logic [5:0] OFF = 6'b000000;

  localparam logic [39:0] M_FULL = {40{1'b1}};
  localparam logic [39:0] M_CTL  = {6'h3f, 34'h0};

  typedef struct {
    int          dut;
    logic [39:0] val;
    logic [39:0] mask;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [39:0] ev(logic [5:0] c, logic [1:0] s, int sc, int fc);
    return {c, s, 16'(sc), 16'(fc)};
  endfunction

  function automatic logic [39:0] observe(int d);
    case (d)
      0:       return {ctl[0], st[0], sc16[0], fc16[0]};
      1:       return {ctl[1], st[1], sc16[1], fc16[1]};
      default: return {ctl[2], st[2], 16'(sc4), 16'(fc4)};
    endcase
  endfunction

  function automatic string fmt(logic [39:0] v);
    return $sformatf("ctl=%b st=%0d sc=%0d fc=%0d", v[39:34], v[33:32], v[31:16], v[15:0]);
  endfunction

  task automatic drive(input logic [3:0] s);
    {rst, load_use_hazard, branch_taken_EX, mem_busy} = s;
  endtask

  task automatic push(input int d, input logic [39:0] v, input logic [39:0] m);
    exp_t e;
    e.dut = d; e.val = v; e.mask = m;
    q.push_back(e);
  endtask

  task automatic apply_reset();
    drive(4'b1000);
    repeat (2) @(posedge clk);
    #1;
    drive(4'b0000);
  endtask

  task automatic test_reset();
    logic [3:0] stim [3] = '{4'b1000, 4'b1000, 4'b0000};
    exp_t e;
    logic [39:0] a;
    for (int i = 0; i < 3; i++) begin
      drive(stim[i]);
      for (int d = 0; d < 3; d++) begin
        if (i < 2) push(d, ev(OFF, 0, 0, 0), M_CTL);
        else       push(d, ev(NRM, 0, 0, 0), M_FULL);
      end
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front(); a = observe(e.dut); n_checks++;
        if ((a & e.mask) !== (e.val & e.mask)) begin
          n_errors++;
          $display("FAIL reset[%0d] dut%0d: got %s, want %s", i, e.dut, fmt(a), fmt(e.val));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_stall_1();
    logic [3:0]  stim [3] = '{4'b0100, 4'b0000, 4'b0000};
    logic [39:0] ex [3];
    exp_t e;
    logic [39:0] a;
    ex = '{ev(LST, 0, 0, 0), ev(NRM, 0, 1, 0), ev(NRM, 0, 1, 0)};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(stim[i]);
      push(0, ex[i], M_FULL);
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front(); a = observe(e.dut); n_checks++;
        if ((a & e.mask) !== (e.val & e.mask)) begin
          n_errors++;
          $display("FAIL load_stall_1[%0d]: got %s, want %s", i, fmt(a), fmt(e.val));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Hazard and branch raised again inside LOAD_STALL must be ignored
  task automatic test_load_stall_3();
    logic [3:0]  stim [5] = '{4'b0100, 4'b0110, 4'b0000, 4'b0000, 4'b0000};
    logic [39:0] ex [5];
    exp_t e;
    logic [39:0] a;
    ex = '{ev(LST, 0, 0, 0), ev(LST, 1, 1, 0), ev(LST, 1, 2, 0), ev(NRM, 0, 3, 0), ev(NRM, 0, 3, 0)};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(stim[i]);
      push(1, ex[i], M_FULL);
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front(); a = observe(e.dut); n_checks++;
        if ((a & e.mask) !== (e.val & e.mask)) begin
          n_errors++;
          $display("FAIL load_stall_3[%0d]: got %s, want %s", i, fmt(a), fmt(e.val));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_priority();
    logic [3:0]  stim [4] = '{4'b0110, 4'b0000, 4'b0010, 4'b0000};
    logic [39:0] ex [4];
    exp_t e;
    logic [39:0] a;
    ex = '{ev(FLS, 0, 0, 0), ev(NRM, 0, 0, 1), ev(FLS, 0, 0, 1), ev(NRM, 0, 0, 2)};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(stim[i]);
      push(0, ex[i], M_FULL);
      push(1, ex[i], M_FULL);
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front(); a = observe(e.dut); n_checks++;
        if ((a & e.mask) !== (e.val & e.mask)) begin
          n_errors++;
          $display("FAIL branch[%0d] dut%0d: got %s, want %s", i, e.dut, fmt(a), fmt(e.val));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // mem_busy during LOAD_STALL (3-cycle instance) and during RUN (1-cycle instance)
  task automatic test_mem_wait();
    logic [3:0]  stim [10] = '{4'b0100, 4'b0000, 4'b0001, 4'b0001, 4'b0001,
                               4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [39:0] ex3 [10];
    logic [39:0] ex1 [10];
    exp_t e;
    logic [39:0] a;
    ex3 = '{ev(LST, 0, 0, 0), ev(LST, 1, 1, 0), ev(FRZ, 1, 2, 0), ev(FRZ, 2, 3, 0), ev(FRZ, 2, 4, 0),
            ev(FRZ, 2, 5, 0), ev(FRX, 2, 6, 0), ev(LST, 1, 7, 0), ev(NRM, 0, 8, 0), ev(NRM, 0, 8, 0)};
    ex1 = '{ev(LST, 0, 0, 0), ev(NRM, 0, 1, 0), ev(FRZ, 0, 1, 0), ev(FRZ, 2, 2, 0), ev(FRZ, 2, 3, 0),
            ev(FRZ, 2, 4, 0), ev(FRX, 2, 5, 0), ev(NRM, 0, 6, 0), ev(NRM, 0, 6, 0), ev(NRM, 0, 6, 0)};
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(stim[i]);
      push(1, ex3[i], M_FULL);
      push(0, ex1[i], M_FULL);
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front(); a = observe(e.dut); n_checks++;
        if ((a & e.mask) !== (e.val & e.mask)) begin
          n_errors++;
          $display("FAIL mem_wait[%0d] dut%0d: got %s, want %s", i, e.dut, fmt(a), fmt(e.val));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [3:0]  stim [4] = '{4'b0100, 4'b1000, 4'b0000, 4'b0000};
    logic [39:0] ex [4];
    exp_t e;
    logic [39:0] a;
    ex = '{ev(LST, 0, 0, 0), ev(OFF, 1, 1, 0), ev(NRM, 0, 0, 0), ev(NRM, 0, 0, 0)};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(stim[i]);
      push(1, ex[i], M_FULL);
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front(); a = observe(e.dut); n_checks++;
        if ((a & e.mask) !== (e.val & e.mask)) begin
          n_errors++;
          $display("FAIL reset_mid_stall[%0d]: got %s, want %s", i, fmt(a), fmt(e.val));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Back-to-back single-cycle load stalls on the 4-bit counter instance
  task automatic test_saturation();
    exp_t e;
    logic [39:0] a;
    apply_reset();
    for (int i = 0; i < 22; i++) begin
      drive((i < 20) ? 4'b0100 : 4'b0000);
      push(2, ev((i < 20) ? LST : NRM, 0, (i < 15) ? i : 15, 0), M_FULL);
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front(); a = observe(e.dut); n_checks++;
        if ((a & e.mask) !== (e.val & e.mask)) begin
          n_errors++;
          $display("FAIL saturation[%0d]: got %s, want %s", i, fmt(a), fmt(e.val));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_load_stall_1();
    test_load_stall_3();
    test_branch_priority();
    test_mem_wait();
    test_reset_mid_stall();
    test_saturation();
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
